// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: decode-side branch inputs, fetch lookup and redirect/statistics outputs
interface branch_resolve_unit_if #(parameter int ADDR_W = 32);
   logic              id_valid;
   logic              id_is_branch;
   logic              id_is_bne;
   logic              id_pred_taken;
   logic [ADDR_W-1:0] id_pc;
   logic [ADDR_W-1:0] id_imm;
   logic              sig_eq;
   logic              operands_ready;
   logic [ADDR_W-1:0] if_pc;
   logic              predict_taken;
   logic              stall_id;
   logic              flush_ifid;
   logic              pc_redirect_valid;
   logic [ADDR_W-1:0] pc_redirect;
   logic [15:0]       branch_count;
   logic [15:0]       mispredict_count;
   modport master (
      output id_valid, id_is_branch, id_is_bne, id_pred_taken, id_pc, id_imm, sig_eq, operands_ready, if_pc,
      input  predict_taken, stall_id, flush_ifid, pc_redirect_valid, pc_redirect, branch_count, mispredict_count
   );
   modport slave (
      input  id_valid, id_is_branch, id_is_bne, id_pred_taken, id_pc, id_imm, sig_eq, operands_ready, if_pc,
      output predict_taken, stall_id, flush_ifid, pc_redirect_valid, pc_redirect, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decode-stage BEQ/BNE resolution, stall, one-cycle redirect/flush, statistics;
// define BRANCH_PREDICT_EN to add the 2-bit branch history table for fetch-time prediction.
module branch_resolve_unit #(
   parameter int ADDR_W      = 32,
   parameter int BHT_ENTRIES = 16
) (
   input logic                 clk,
   input logic                 reset,
   branch_resolve_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;
   state_t            state_q;
   logic              redirect_q;
   logic [ADDR_W-1:0] pc_redirect_q;
   logic [15:0]       branch_cnt_q, mispred_cnt_q;
   logic              branch, resolve, taken, pred, mispredict;
   logic [ADDR_W-1:0] fall_through, target;
   always_comb begin
      branch       = bus.id_valid & bus.id_is_branch & (state_q != S_REDIRECT);
      resolve      = branch & bus.operands_ready;
      taken        = bus.sig_eq ^ bus.id_is_bne;
      mispredict   = resolve & (taken != pred);
      fall_through = bus.id_pc + ADDR_W'(4);
      target       = fall_through + (bus.id_imm << 2);
   end
   assign bus.stall_id          = branch & !bus.operands_ready;
   assign bus.flush_ifid        = redirect_q;
   assign bus.pc_redirect_valid = redirect_q;
   assign bus.pc_redirect       = pc_redirect_q;
   assign bus.branch_count      = branch_cnt_q;
   assign bus.mispredict_count  = mispred_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         redirect_q    <= 1'b0;
         pc_redirect_q <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q    <= mispredict ? S_REDIRECT : bus.stall_id ? S_WAIT : S_IDLE;
         redirect_q <= mispredict;
         if (mispredict) pc_redirect_q <= taken ? target : fall_through;
         if (resolve) branch_cnt_q <= branch_cnt_q + 16'(branch_cnt_q != 16'hFFFF);
         if (mispredict) mispred_cnt_q <= mispred_cnt_q + 16'(mispred_cnt_q != 16'hFFFF);
      end
   end
`ifdef BRANCH_PREDICT_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [IDX_W-1:0] upd_idx, look_idx;
   logic             unused;
   assign upd_idx           = bus.id_pc[IDX_W+1:2];
   assign look_idx          = bus.if_pc[IDX_W+1:2];
   assign pred              = bus.id_pred_taken;
   assign bus.predict_taken = bht_q[look_idx][1];
   assign unused            = ^{bus.if_pc[ADDR_W-1:IDX_W+2], bus.if_pc[1:0]};
   // Lookup reads the registered table, so a same-cycle update is seen only next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (resolve) begin
         bht_q[upd_idx] <= taken ? bht_q[upd_idx] + 2'(bht_q[upd_idx] != 2'b11)
                                 : bht_q[upd_idx] - 2'(bht_q[upd_idx] != 2'b00);
      end
   end
`else
   logic unused;
   assign pred              = 1'b0;
   assign bus.predict_taken = 1'b0;
   assign unused            = ^{bus.id_pred_taken, bus.if_pc};
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with hand-computed expectations for branch_resolve_unit
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_miss = 0;
   branch_resolve_unit_if #(.ADDR_W(32)) bus ();
   branch_resolve_unit #(.ADDR_W(32), .BHT_ENTRIES(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.id_valid = 1'b0; bus.id_is_branch = 1'b0; bus.id_is_bne = 1'b0; bus.id_pred_taken = 1'b0;
      bus.id_pc = '0; bus.id_imm = '0; bus.sig_eq = 1'b0; bus.operands_ready = 1'b0;
   endtask
   task automatic br(input logic bne, input logic eq, input logic pred, input logic rdy,
                     input logic [31:0] pc, input logic [31:0] imm);
      bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_is_bne = bne; bus.id_pred_taken = pred;
      bus.id_pc = pc; bus.id_imm = imm; bus.sig_eq = eq; bus.operands_ready = rdy;
      #1;
   endtask
   initial begin
      idle();
      bus.if_pc = 32'h40;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_stall", 32'(bus.stall_id), 0);
      chk("rst_flush", 32'(bus.flush_ifid), 0);
      chk("rst_rv", 32'(bus.pc_redirect_valid), 0);
      chk("rst_pc", bus.pc_redirect, 0);
      chk("rst_bcnt", 32'(bus.branch_count), 0);
      chk("rst_mcnt", 32'(bus.mispredict_count), 0);
      chk("rst_pred", 32'(bus.predict_taken), 0);
      // BEQ taken, predicted not-taken: redirect to 0x100+4+12
      br(0, 1, 0, 1, 32'h100, 32'd3);
      chk("beq_nostall", 32'(bus.stall_id), 0);
      step(); idle(); #1;
      chk("beq_rv", 32'(bus.pc_redirect_valid), 1);
      chk("beq_flush", 32'(bus.flush_ifid), 1);
      chk("beq_pc", bus.pc_redirect, 32'h110);
      chk("beq_mcnt", 32'(bus.mispredict_count), 1);
      chk("beq_bcnt", 32'(bus.branch_count), 1);
      step();
      chk("beq_rv_drop", 32'(bus.pc_redirect_valid), 0);
      chk("beq_pc_hold", bus.pc_redirect, 32'h110);
      // BNE with equal operands: not taken, correctly predicted
      br(1, 1, 0, 1, 32'h200, 32'd8);
      step(); idle(); #1;
      chk("bne_rv", 32'(bus.pc_redirect_valid), 0);
      chk("bne_bcnt", 32'(bus.branch_count), 2);
      chk("bne_mcnt", 32'(bus.mispredict_count), 1);
      // Operands late for 3 cycles, backward branch to itself
      for (int i = 0; i < 3; i++) begin
         br(0, 1, 0, 0, 32'h300, 32'hFFFF_FFFF);
         chk($sformatf("wait_stall%0d", i), 32'(bus.stall_id), 1);
         step();
      end
      br(0, 1, 0, 1, 32'h300, 32'hFFFF_FFFF);
      chk("wait_res_stall", 32'(bus.stall_id), 0);
      chk("wait_no_rv", 32'(bus.pc_redirect_valid), 0);
      step();
      chk("wait_rv", 32'(bus.pc_redirect_valid), 1);
      chk("wait_pc", bus.pc_redirect, 32'h300);
      // Wrong-path branch during REDIRECT must be ignored
      br(0, 1, 0, 0, 32'h500, 32'd1);
      chk("redir_nostall", 32'(bus.stall_id), 0);
      br(0, 1, 0, 1, 32'h500, 32'd1);
      step(); idle(); #1;
      chk("redir_ign_rv", 32'(bus.pc_redirect_valid), 0);
      chk("redir_ign_bcnt", 32'(bus.branch_count), 3);
      chk("redir_ign_mcnt", 32'(bus.mispredict_count), 2);
      // Target wraps past the top of the address space
      br(1, 0, 0, 1, 32'hFFFF_FFFC, 32'd0);
      step(); idle(); #1;
      chk("wrap_rv", 32'(bus.pc_redirect_valid), 1);
      chk("wrap_pc", bus.pc_redirect, 32'h0);
      step();
      // Reset while waiting on operands
      br(0, 1, 0, 0, 32'h600, 32'd2);
      chk("rstw_stall", 32'(bus.stall_id), 1);
      step();
      reset = 1'b1;
      bus.operands_ready = 1'b1;
      step();
      reset = 1'b0; idle(); #1;
      chk("rstw_stall_after", 32'(bus.stall_id), 0);
      chk("rstw_rv", 32'(bus.pc_redirect_valid), 0);
      chk("rstw_bcnt", 32'(bus.branch_count), 0);
      chk("rstw_mcnt", 32'(bus.mispredict_count), 0);
      step();
      chk("rstw_rv2", 32'(bus.pc_redirect_valid), 0);
`ifdef BRANCH_PREDICT_EN
      bus.if_pc = 32'h40; #1;
      chk("bht_init", 32'(bus.predict_taken), 0);
      br(0, 1, 0, 1, 32'h40, 32'd4);
      chk("bht_same_cycle", 32'(bus.predict_taken), 0);
      step(); idle(); #1;
      chk("bht_rv1", 32'(bus.pc_redirect_valid), 1);
      chk("bht_pred", 32'(bus.predict_taken), 1);
      step();
      br(0, 1, 1, 1, 32'h40, 32'd4);
      step(); idle(); #1;
      chk("bht_rv2", 32'(bus.pc_redirect_valid), 0);
      chk("bht_mcnt", 32'(bus.mispredict_count), 1);
      chk("bht_bcnt", 32'(bus.branch_count), 2);
      reset = 1'b1; step(); reset = 1'b0; #1;
`else
      // Prediction bit is ignored without a BHT
      br(0, 1, 1, 1, 32'h40, 32'd4);
      step(); idle(); #1;
      chk("nopred_taken_rv", 32'(bus.pc_redirect_valid), 1);
      chk("nopred_taken_pc", bus.pc_redirect, 32'h54);
      step();
      br(0, 0, 1, 1, 32'h40, 32'd4);
      step(); idle(); #1;
      chk("nopred_nt_rv", 32'(bus.pc_redirect_valid), 0);
      chk("nopred_mcnt", 32'(bus.mispredict_count), 1);
      chk("nopred_bcnt", 32'(bus.branch_count), 2);
      reset = 1'b1; step(); reset = 1'b0; #1;
`endif
      // Branch counter saturation with back-to-back correctly predicted branches
      br(1, 1, 0, 1, 32'h700, 32'd1);
      repeat (65534) step();
      chk("sat_fffe", 32'(bus.branch_count), 32'hFFFE);
      repeat (6) step();
      chk("sat_ffff", 32'(bus.branch_count), 32'hFFFF);
      chk("sat_mcnt", 32'(bus.mispredict_count), 0);
      idle();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Decode-stage branch resolution block sitting directly downstream of the 32-bit equality comparator. Consumes the comparator's equality flag for BEQ/BNE, computes the actual direction and target, stalls decode while branch operands are not yet forwarded, and issues a one-cycle PC redirect plus IF/ID flush on a mispredict. Also keeps branch statistics counters and, optionally, a 2-bit branch history table for fetch-time prediction.

## Interface
- `ADDR_W`, default 32: PC/target width.
- `BHT_ENTRIES`, default 16: BHT entries, power of two; index = `pc[log2(BHT_ENTRIES)+1:2]`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `id_valid` in 1: decode slot holds a valid instruction.
- `id_is_branch` in 1: decode instruction is BEQ or BNE.
- `id_is_bne` in 1: 1 = BNE, 0 = BEQ.
- `id_pred_taken` in 1: prediction carried with the instruction from fetch.
- `id_pc` in ADDR_W: branch PC.
- `id_imm` in ADDR_W: sign-extended word offset.
- `sig_eq` in 1: comparator equality result for the branch operands.
- `operands_ready` in 1: hazard unit reports both comparator operands valid this cycle.
- `if_pc` in ADDR_W: fetch PC for prediction lookup.
- `predict_taken` out 1: prediction for `if_pc` (combinational).
- `stall_id` out 1: hold PC and IF/ID (combinational).
- `flush_ifid` out 1: kill the IF/ID contents.
- `pc_redirect_valid` out 1: load `pc_redirect` into PC.
- `pc_redirect` out ADDR_W: corrected fetch address.
- `branch_count` out 16: resolved branches, saturating.
- `mispredict_count` out 16: mispredicted branches, saturating.

## Operation
- Actual direction: `taken = sig_eq XOR id_is_bne`.
- Target: `id_pc + 4 + (id_imm << 2)`, truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
- Fall-through: `id_pc + 4`, also wrapping.
- A branch is *resolvable* when the state is IDLE or WAIT and `id_valid & id_is_branch & operands_ready` is true.
- FSM states:
  - IDLE:
    - Branch present and operands not ready: go to WAIT and assert `stall_id`.
    - Resolvable: resolve the branch. On a mispredict (`taken != id_pred_taken`), register the target (if taken) or the fall-through (if not taken) into `pc_redirect` and go to REDIRECT. Otherwise stay in IDLE.
  - WAIT:
    - `stall_id` = `!operands_ready`.
    - Upstream holds the `id_*` inputs stable.
    - When operands become ready, resolve exactly as in IDLE.
  - REDIRECT:
    - `pc_redirect_valid` = 1 and `flush_ifid` = 1 for exactly one cycle, then go to IDLE.
    - `id_*` inputs are ignored in this state (they are the wrong-path instruction).
- Every resolution increments `branch_count`. Every mispredict also increments `mispredict_count`. Both counters hold at 0xFFFF.
- `pc_redirect` holds its last value outside REDIRECT.
- Non-branch or invalid decode instructions have no effect.

## Timing
- Reset values: state IDLE; `stall_id`, `flush_ifid`, `pc_redirect_valid` = 0; `pc_redirect` = 0; both counters = 0; all BHT entries = 2'b01.
- Resolution occurs in cycle N, the first cycle with operands ready. Redirect and flush are asserted in cycle N+1 (registered), so the mispredict penalty is 1 cycle of redirect.
- `stall_id` is combinational. It is never asserted in the resolving cycle or in REDIRECT.
- Reset during WAIT or REDIRECT returns to IDLE with no redirect issued. Counters and the BHT are reset.
- Counters update on the clock edge that ends cycle N.

## Configuration
- `BRANCH_PREDICT_EN` defined:
  - BHT of `BHT_ENTRIES` 2-bit saturating counters.
  - `predict_taken` = MSB of `BHT[if_pc index]`.
  - At resolution, the `id_pc` entry increments on taken and decrements on not-taken, saturating at 0 and 3.
  - If a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update value.
- `BRANCH_PREDICT_EN` undefined:
  - No BHT storage; `predict_taken` = 0.
  - `id_pred_taken` is ignored and treated as 0, so every taken branch redirects and no not-taken branch does.

## Test plan
- BEQ at `id_pc`=0x100, `id_imm`=3, `sig_eq`=1, pred 0, ready: next cycle `pc_redirect_valid`=`flush_ifid`=1, `pc_redirect`=0x110; `mispredict_count`=1.
- BNE, `sig_eq`=1, pred 0, ready: no redirect; `branch_count` +1, `mispredict_count` unchanged.
- BEQ with `operands_ready` low for 3 cycles: `stall_id`=1 for exactly those 3 cycles, then resolution; redirect 1 cycle later.
- `id_pc`=0xFFFFFFFC, `id_imm`=0, taken: `pc_redirect`=0x00000000 (wrap).
- `reset` asserted during WAIT: next cycle `stall_id`=0, no redirect, counters 0.
- With `BRANCH_PREDICT_EN`: same BEQ at 0x40 taken twice. First resolution mispredicts (entry 01→10). A lookup with `if_pc`=0x40 then gives `predict_taken`=1. Second resolution with pred 1 gives no redirect.
